mux_arb_nto1: RTL and testbench
===============================

// Module: mux_arb_nto1
// PURPOSE
//  Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshake on every port.
//  Picks one requesting input channel per cycle (fixed-priority or round-robin) and registers the chosen word.
//  Registered output, 1-cycle latency, full throughput.
//  Sits between datapath producers (ALU result, load data, immediate path) and a shared consumer (register-file write port).
// PARAMETERS
//  N       4   number of input channels; legal range 2..16
//  WIDTH   16  data width of every channel and of the output
//  RR      1   arbitration policy: 1 = round-robin, 0 = fixed priority (channel 0 highest)
//  SEL_W   $clog2(N)  derived; width of the channel index (localparam, not overridable)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous reset, active-high
//  in_valid   in   N          per-channel request; bit i belongs to channel i
//  in_data    in   N*WIDTH    packed data; channel i occupies [i*WIDTH +: WIDTH]
//  in_ready   out  N          per-channel accept; one-hot or zero
//  out_valid  out  1          output register holds a word
//  out_data   out  WIDTH      registered selected word
//  out_sel    out  SEL_W      index of the channel that supplied out_data
//  out_ready  in   1          consumer accepts out_data this cycle
// BEHAVIOUR
//  Reset:
//   - On rst high, out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
//   - This takes effect immediately, without waiting for clk.
//   - Any word in flight is discarded.
//   - in_ready is combinational and therefore also reads 0 during reset.
//  Load condition:
//   - load = !out_valid | out_ready.
//   - The output register takes a new word only when load=1.
//  Grant:
//   - grant = arbitration over in_valid, gated by load.
//   - in_ready = grant, so in_ready[i] can be 1 only when in_valid[i]=1.
//  Transfer:
//   - Channel i transfers on a clock edge when in_valid[i] & in_ready[i].
//   - Next cycle: out_data = that channel's word, out_sel = i, out_valid = 1.
//  Drain:
//   - If out_valid & out_ready and no channel is granted, out_valid goes to 0 next cycle.
//   - out_data and out_sel keep their last value.
//  Stall:
//   - While out_valid & !out_ready, out_data and out_sel hold stable and in_ready = 0.
//  Simultaneous drain and load:
//   - The new word replaces the old one in the same edge.
//   - No bubble is inserted, so back-to-back transfers give 1 word/cycle.
//  Round-robin (RR=1):
//   - Search order is rr_ptr, rr_ptr+1, ..., N-1, 0, ..., rr_ptr-1.
//   - The first requester in that order wins.
//   - After a transfer from channel g, rr_ptr = (g+1) mod N; wrap from N-1 goes to 0.
//   - rr_ptr changes only on a transfer.
//  Fixed priority (RR=0):
//   - The lowest-index requester wins; rr_ptr is unused.
//  Other rules:
//   - in_valid=0 on all channels: no grant, registers unchanged except for drain.
//   - A producer must hold in_valid and in_data stable until it is accepted.
//   - The block need not check this rule.
//   - The block is purely a forwarding stage: no data arithmetic and no width change.
//   - When N is not a power of 2, rr_ptr never takes a value >= N.
// STRUCTURE
//  Shared package (mux_pkg):
//   - ARB_FIXED = 0 and ARB_RR = 1 policy constants.
//   - Default DATA_WIDTH = 16.
//  Sub-module rr_arbiter:
//   - Parameters N and RR.
//   - Ports clk, rst, req[N], en, grant[N], gidx[SEL_W].
//   - Owns rr_ptr; updates it when en & |req.
//  Top level:
//   - Holds the load logic, the output register and the packed-data index mux.
// TESTING
//  1. Reset
//     - Stimulus: assert rst mid-stream with out_valid=1 and no clk edge.
//     - Required: out_valid=0, out_data=0, out_sel=0 at once; in_ready=0 while rst is high.
//  2. Single channel
//     - Stimulus: N=4, in_valid=4'b0100, in_data[2]=16'hBEEF, out_ready=1.
//     - Required: in_ready=4'b0100; next cycle out_valid=1, out_data=16'hBEEF, out_sel=2.
//  3. Round-robin fairness
//     - Stimulus: RR=1, all 4 channels valid continuously with data 16'h000i, out_ready=1.
//     - Required: out_sel sequence 0,1,2,3,0,1 at one word per cycle with no bubbles.
//  4. Fixed priority
//     - Stimulus: RR=0, in_valid=4'b1010 held for 3 cycles.
//     - Required: channel 1 is granted every cycle; channel 3 is never granted.
//  5. Backpressure
//     - Stimulus: out_ready=0 for 3 cycles with out_valid=1 and out_data=16'h1234.
//     - Required: out_data stays 16'h1234 and in_ready=0 throughout.
//     - Stimulus: then raise out_ready with channel 0 waiting.
//     - Required: channel 0 is accepted in that same cycle.
//  6. Drain and wrap
//     - Stimulus: N=3, RR=1; transfer from channel 2, then in_valid=0 with out_ready=1.
//     - Required: out_valid falls to 0; rr_ptr=0.
//     - Stimulus: then in_valid=3'b011.
//     - Required: channel 0 is granted.

Source files
------------

// File: rtl/mux_arb_nto1_pkg.sv
// Shared definitions for the N-to-1 registered arbitrating multiplexer.
//   ARB_FIXED / ARB_RR : arbitration policy selectors
//   DATA_WIDTH         : default channel data width
//   wrap_inc()         : modulo-n increment used for the round-robin pointer
package mux_pkg;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;
  localparam int DATA_WIDTH = 16;

  function automatic int wrap_inc(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/mux_arb_nto1_arb.sv
// Arbiter for mux_arb_nto1: fixed priority (channel 0 highest) or round-robin.
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-channel request vector
//   en       : grant enable; no grant and no pointer update when low
//   grant    : one-hot (or zero) grant, gated by en
//   gidx     : index of the winning requester (valid when |grant)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  RR    = ARB_RR,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] gidx
);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     win_c;
  logic             found_c;
  int               idx_c;

  // Scan from the pointer (round-robin) or from channel 0 (fixed), wrapping
  // by subtraction so the search index never leaves 0..N-1.
  always_comb begin
    win_c   = '0;
    gidx    = '0;
    found_c = 1'b0;
    idx_c   = 0;
    for (int k = 0; k < N; k++) begin
      if (RR == ARB_RR) begin
        idx_c = int'(rr_ptr_q) + k;
        if (idx_c >= N) idx_c = idx_c - N;
      end else begin
        idx_c = k;
      end
      if (!found_c && req[idx_c]) begin
        found_c      = 1'b1;
        win_c[idx_c] = 1'b1;
        gidx         = SEL_W'(idx_c);
      end
    end
  end

  assign grant = en ? win_c : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (en && found_c) rr_ptr_d = SEL_W'(wrap_inc(int'(gidx), N));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-input, WIDTH-bit registered multiplexer with valid/ready on every port.
// One requesting channel is chosen per cycle and its word registered with
// one cycle of latency and full throughput.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : per-channel request
//   in_data    : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   : per-channel accept, one-hot or zero
//   out_valid  : output register holds a word
//   out_data   : registered selected word
//   out_sel    : channel that supplied out_data
//   out_ready  : consumer accepts out_data this cycle
module mux_arb_nto1
  import mux_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  WIDTH = DATA_WIDTH,
  parameter int  RR    = ARB_RR,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d;
  logic               load;
  logic               arb_en;
  logic               xfer;
  logic [N-1:0]       grant;
  logic [SEL_W-1:0]   gidx;
  logic [WIDTH-1:0]   chan [N];
  logic [WIDTH-1:0]   sel_data;

  assign load   = !out_valid_q || out_ready;
  // rst gates the enable so in_ready reads 0 while reset is held.
  assign arb_en = load && !rst;

  rr_arbiter #(.N(N), .RR(RR)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (in_valid),
    .en    (arb_en),
    .grant (grant),
    .gidx  (gidx)
  );

  assign in_ready = grant;
  assign xfer     = |grant;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Grant is one-hot, so an AND-OR select avoids indexing past N when N
  // is not a power of two.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = sel_data | chan[i];
    end
  end

  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d  = xfer ? sel_data : out_data_q;
    out_sel_d   = xfer ? gidx     : out_sel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
module tb_mux_arb_nto1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: N=4, round-robin
  logic [3:0]  a_iv = '0;
  logic [63:0] a_id = '0;
  logic [3:0]  a_ir;
  logic        a_ov;
  logic [15:0] a_od;
  logic [1:0]  a_os;
  logic        a_or = 1'b0;

  // DUT B: N=4, fixed priority
  logic [3:0]  b_iv = '0;
  logic [63:0] b_id = '0;
  logic [3:0]  b_ir;
  logic        b_ov;
  logic [15:0] b_od;
  logic [1:0]  b_os;
  logic        b_or = 1'b0;

  // DUT C: N=3, round-robin
  logic [2:0]  c_iv = '0;
  logic [47:0] c_id = '0;
  logic [2:0]  c_ir;
  logic        c_ov;
  logic [15:0] c_od;
  logic [1:0]  c_os;
  logic        c_or = 1'b0;

  mux_arb_nto1 #(.N(4), .WIDTH(16), .RR(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_sel(a_os), .out_ready(a_or));

  mux_arb_nto1 #(.N(4), .WIDTH(16), .RR(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_sel(b_os), .out_ready(b_or));

  mux_arb_nto1 #(.N(3), .WIDTH(16), .RR(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
    .out_valid(c_ov), .out_data(c_od), .out_sel(c_os), .out_ready(c_or));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Power-on reset
    repeat (2) step();
    chk("por_a_valid", a_ov, 0);
    chk("por_a_ready", a_ir, 0);
    rst = 1'b0;
    step();

    // Single channel on A
    a_iv = 4'b0100;
    a_id = '0;
    a_id[32 +: 16] = 16'hBEEF;
    a_or = 1'b1;
    #1;
    chk("single_ready", a_ir, 4'b0100);
    step();
    chk("single_valid", a_ov, 1);
    chk("single_data", a_od, 16'hBEEF);
    chk("single_sel", a_os, 2);
    chk("single_ptr", dut_a.u_arb.rr_ptr_q, 3);

    // Reset mid-stream, no clock edge; requests pending on all channels
    a_iv = 4'b1111;
    a_id = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
    rst = 1'b1;
    #2;
    chk("rst_valid", a_ov, 0);
    chk("rst_data", a_od, 0);
    chk("rst_sel", a_os, 0);
    chk("rst_ready", a_ir, 0);
    chk("rst_ptr", dut_a.u_arb.rr_ptr_q, 0);
    rst = 1'b0;
    #1;
    chk("rr_first_ready", a_ir, 4'b0001);

    // Round-robin fairness: 0,1,2,3,0,1 back-to-back
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_valid", a_ov, 1);
      chk("rr_sel", a_os, k % 4);
      chk("rr_data", a_od, k % 4);
    end
    a_iv = '0;
    step();
    chk("rr_drain_valid", a_ov, 0);

    // Backpressure on A
    a_iv = 4'b0001;
    a_id = '0;
    a_id[15:0] = 16'h1234;
    step();
    chk("bp_load_data", a_od, 16'h1234);
    a_or = 1'b0;
    a_id[15:0] = 16'h0ABC;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall_ready", a_ir, 0);
      step();
      chk("bp_stall_valid", a_ov, 1);
      chk("bp_stall_data", a_od, 16'h1234);
      chk("bp_stall_sel", a_os, 0);
    end
    a_or = 1'b1;
    #1;
    chk("bp_release_ready", a_ir, 4'b0001);
    step();
    chk("bp_release_data", a_od, 16'h0ABC);
    chk("bp_release_valid", a_ov, 1);
    a_iv = '0;

    // Fixed priority on B
    b_iv = 4'b1010;
    b_id = {16'h3333, 16'h0000, 16'h1111, 16'h0000};
    b_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fixed_ready", b_ir, 4'b0010);
      step();
      chk("fixed_sel", b_os, 1);
      chk("fixed_data", b_od, 16'h1111);
    end
    b_iv = '0;

    // Drain and wrap on C (N=3)
    c_iv = 3'b100;
    c_id = {16'h2222, 16'h0000, 16'h0000};
    c_or = 1'b1;
    #1;
    chk("wrap_ready", c_ir, 3'b100);
    step();
    chk("wrap_valid", c_ov, 1);
    chk("wrap_sel", c_os, 2);
    c_iv = '0;
    step();
    chk("drain_valid", c_ov, 0);
    chk("drain_sel_hold", c_os, 2);
    chk("drain_data_hold", c_od, 16'h2222);
    chk("wrap_ptr", dut_c.u_arb.rr_ptr_q, 0);
    c_iv = 3'b011;
    c_id = {16'h0000, 16'h0B0B, 16'h0A0A};
    #1;
    chk("wrap_grant", c_ir, 3'b001);
    step();
    chk("wrap_next_sel", c_os, 0);
    chk("wrap_next_data", c_od, 16'h0A0A);
    c_iv = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
